riscv_trace_buffer: RTL and testbench
=====================================

# riscv_trace_buffer

Parametrised instruction-trace capture block for the RISC_V core. It records the {PC, Instr} stream in a circular buffer of configurable depth. A PC-match trigger with a programmable post-trigger window freezes the buffer. The frozen history is then drained oldest-first through a read handshake. It sits beside the core (tapping PC/Instr and a retire strobe) and replaces ad-hoc simulation-only monitoring with a synthesizable, queryable trace.

## Interface
Parameters:
- XLEN, 32, PC width in bits
- DEPTH, 16, entries in the buffer; power of two, at least 2
- POST_TRIG, 4, entries captured after the trigger entry; range 0..DEPTH-1

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high; clears all state
- arm  in  1  single-cycle pulse; clears the buffer and enters ARMED
- trig_en  in  1  enables the PC-match trigger
- trig_pc  in  XLEN  trigger PC value
- cap_valid  in  1  cap_pc/cap_instr hold a retired instruction this cycle
- cap_pc  in  XLEN  retired PC
- cap_instr  in  32  retired instruction word
- state  out  2  0=IDLE, 1=ARMED, 2=POST, 3=FROZEN
- frozen  out  1  equals (state==FROZEN)
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH
- rd_en  in  1  read request, honoured only in FROZEN with count>0
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_data  out  XLEN+32 (+16 with TRACE_CYCLE_EN)  {pc, instr}, plus {cycle} in the LSBs when TRACE_CYCLE_EN is defined
- rd_empty  out  1  equals (count==0)

## Operation
- **Reset values:** state=IDLE, frozen=0, count=0, rd_valid=0, rd_data=0, rd_empty=1. The write pointer, post counter and cycle counter are all 0.
- **IDLE:** captures are ignored. arm moves to ARMED.
- **arm pulse (any state):** clears the write pointer and count, and moves to ARMED. arm has priority; a cap_valid in the same cycle is not written.
- **Write path (ARMED or POST):**
  - On cap_valid, the entry is written at wptr.
  - wptr advances modulo DEPTH.
  - count increments and saturates at DEPTH; the oldest entry is overwritten on wrap.
- **Trigger in ARMED:** cap_valid && trig_en && cap_pc==trig_pc.
  - The triggering entry is written.
  - If POST_TRIG==0, go to FROZEN.
  - Otherwise load the post counter with POST_TRIG and go to POST.
  - Triggers are ignored outside ARMED.
- **POST:** each cap_valid write decrements the post counter. The write that brings it to 0 moves to FROZEN. Cycles without cap_valid do not decrement.
- **FROZEN:**
  - No writes.
  - The read pointer starts at (wptr - count) mod DEPTH, i.e. the oldest entry.
  - rd_en with count>0 returns the entry at rptr, advances rptr and decrements count.
  - rd_en with count==0 is ignored: no rd_valid, no state change.
- Draining does not leave FROZEN; only arm or reset does.
- rd_en outside FROZEN is ignored.

## Timing
- **Write:** an entry accepted at edge N is reflected in count after edge N.
- **Freeze:** state/frozen change at the same edge as the final post-trigger write.
- **Read latency:** one cycle. rd_en sampled at edge N gives rd_valid=1 and rd_data after edge N; rd_valid drops after edge N+1 unless rd_en is still high.
- **Back-to-back reads:** rd_en held high drains one entry per cycle.
- rd_data holds its last value when rd_valid=0.
- **Reset mid-operation:** reset asynchronously forces all reset values. Buffer RAM contents are don't-care, because count=0 masks them.

## Configuration
- **TRACE_CYCLE_EN defined:**
  - A 16-bit free-running cycle counter (reset 0, increments every clk, wraps 0xFFFF→0) is stored with each entry.
  - rd_data is XLEN+48 bits: {pc, instr, cycle}.
- **TRACE_CYCLE_EN undefined:** there is no counter and rd_data is XLEN+32 bits: {pc, instr}.
- All other behaviour is identical in both builds.

## Test plan
Defaults for all scenarios: DEPTH=16, POST_TRIG=4, XLEN=32.
1. **Reset:** assert reset for 2 cycles -> state=0, frozen=0, count=0, rd_empty=1, rd_valid=0. Pulse rd_en in IDLE -> no rd_valid.
2. **Fill, no trigger:** arm, trig_en=0, then 10 cap_valid with PC=0x00,0x04..0x24 -> count=10, state=ARMED. Then 10 more captures -> count saturates at 16.
3. **Wrap + trigger with gaps in the post window:**
   - Setup: arm, trig_en=1, trig_pc=0x3C; feed PCs 0x00..0x4C step 4, 20 entries; insert idle cycles during the post window.
   - Required: FROZEN after the PC=0x4C write, count=16.
   - Drain: rd_en held 17 cycles -> 16 rd_valid pulses, PCs 0x10..0x4C in order, then rd_empty=1 and no 17th pulse.
4. **Priority and re-arm:**
   - While FROZEN, assert arm together with cap_valid (PC=0x100) -> state=ARMED, count=0.
   - Next cap_valid with PC=0x104 -> count=1, and the first read after freezing is 0x104.
5. **Reset mid-POST:** trigger, then 2 post writes, then assert reset -> state=IDLE, count=0 immediately, without waiting for a clock edge.
6. **TRACE_CYCLE_EN build:** capture at cycles 5 and 7 after reset -> stamps 5 and 7. Run past 65536 cycles -> the stamp wraps to 0.

Source files
------------

// File: rtl/riscv_trace_buffer.sv
// Instruction-trace capture: circular {pc, instr} buffer with PC-match trigger,
// post-trigger window and oldest-first drain. Define TRACE_CYCLE_EN to add 16-bit cycle stamps.
module riscv_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
`ifdef TRACE_CYCLE_EN
  localparam int DW = XLEN + 48
`else
  localparam int DW = XLEN + 32
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic          cap_valid,
  input  logic [XLEN-1:0] cap_pc,
  input  logic [31:0]   cap_instr,
  output logic [1:0]    state,
  output logic          frozen,
  output logic [CW-1:0] count,
  input  logic          rd_en,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_empty
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   post_q;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rptr;
  logic [DW-1:0]   entry;
  logic            wr_en, hit, rd_fire;

`ifdef TRACE_CYCLE_EN
  logic [15:0] cycle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 16'd1;
  end

  assign entry = {cap_pc, cap_instr, cycle_q};
`else
  assign entry = {cap_pc, cap_instr};
`endif

  assign wr_en   = cap_valid && !arm && (state_q == S_ARMED || state_q == S_POST);
  assign hit     = cap_valid && trig_en && (cap_pc == trig_pc) && (state_q == S_ARMED);
  // Oldest entry sits count slots behind wptr; it moves forward as count drains.
  assign rptr    = wptr_q - count_q[AW-1:0];
  // Read handshake: rd_en is a request with no back-pressure; it is accepted only
  // in FROZEN with count>0, and each acceptance yields exactly one rd_valid pulse
  // carrying rd_data on the following cycle.
  assign rd_fire = rd_en && !arm && (state_q == S_FROZEN) && (count_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: if (hit) state_d = (POST_TRIG == 0) ? S_FROZEN : S_POST;
        S_POST:  if (cap_valid && post_q == CW'(1)) state_d = S_FROZEN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q   <= '0;
      count_q  <= '0;
      post_q   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rptr];
      if (arm) begin
        wptr_q  <= '0;
        count_q <= '0;
      end else if (wr_en) begin
        wptr_q <= wptr_q + AW'(1);
        if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
      end else if (rd_fire) begin
        count_q <= count_q - CW'(1);
      end
      if (hit) post_q <= CW'(POST_TRIG);
      else if (wr_en && state_q == S_POST) post_q <= post_q - CW'(1);
    end
  end

  // Storage has no reset: count masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr_q] <= entry;
  end

  assign state    = state_q;
  assign frozen   = (state_q == S_FROZEN);
  assign count    = count_q;
  assign rd_empty = (count_q == '0);

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: directed captures, expected read entries queued
// at capture time and popped by a monitor on every rd_valid.
module tb_riscv_trace_buffer;
`ifdef TRACE_CYCLE_EN
  localparam int DW = 80;
`else
  localparam int DW = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arm = 1'b0;
  logic          trig_en = 1'b0;
  logic [31:0]   trig_pc = '0;
  logic          cap_valid = 1'b0;
  logic [31:0]   cap_pc = '0;
  logic [31:0]   cap_instr = '0;
  logic [1:0]    state;
  logic          frozen;
  logic [4:0]    count;
  logic          rd_en = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_empty;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   tb_cyc;

  riscv_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(4)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .state(state), .frozen(frozen), .count(count), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_empty(rd_empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference cycle count: a capture issued now is stamped with this value
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= '0;
    else       tb_cyc <= tb_cyc + 16'd1;
  end

  function automatic logic [DW-1:0] exp_entry(input logic [31:0] pc);
`ifdef TRACE_CYCLE_EN
    return {pc, 16'hC0DE, pc[15:0], tb_cyc};
`else
    return {pc, 16'hC0DE, pc[15:0]};
`endif
  endfunction

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  // push_exp: the entry is expected to survive until the drain
  task automatic cap(input logic [31:0] pc, input bit push_exp);
    cap_valid = 1'b1;
    cap_pc    = pc;
    cap_instr = {16'hC0DE, pc[15:0]};
    if (push_exp) exp_q.push_back(exp_entry(pc));
    step();
    cap_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    rd_en = 1'b1;
    repeat (cycles) step();
    rd_en = 1'b0;
    step();
    step();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rd_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_rd_valid: got %0h expected no pulse", rd_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          tests_failed++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  initial begin
    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state", state, 2'd0);
    check("reset_frozen", frozen, 1'b0);
    check("reset_count", count, 5'd0);
    check("reset_empty", rd_empty, 1'b1);
    check("reset_rd_valid", rd_valid, 1'b0);
    check("reset_rd_data", rd_data, '0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("idle_rd_no_valid", rd_valid, 1'b0);
    cap(32'h0, 1'b0);
    check("idle_ignores_cap", count, 5'd0);

    // 2. fill without trigger (matching PC with trig_en=0 must not trigger)
    trig_en = 1'b0;
    trig_pc = 32'h10;
    pulse_arm();
    check("arm_state", state, 2'd1);
    for (int i = 0; i < 10; i++) cap(32'(i * 4), 1'b0);
    check("fill10_count", count, 5'd10);
    check("fill10_state", state, 2'd1);
    for (int i = 10; i < 20; i++) cap(32'(i * 4), 1'b0);
    check("fill_sat_count", count, 5'd16);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("armed_rd_ignored", rd_valid, 1'b0);

    // 3. wrap + trigger, idle gaps inside the post window
    pulse_arm();
    check("rearm_count", count, 5'd0);
    trig_en = 1'b1;
    trig_pc = 32'h3C;
    for (int i = 0; i < 20; i++) begin
      cap(32'(i * 4), i >= 4);
      if (i == 15) check("trig_post_state", state, 2'd2);
      if (i >= 15 && i < 19) begin
        step();
        step();
      end
      if (i == 18) check("post_not_frozen", frozen, 1'b0);
    end
    check("freeze_state", state, 2'd3);
    check("freeze_frozen", frozen, 1'b1);
    check("freeze_count", count, 5'd16);
    cap(32'h80, 1'b0);
    check("frozen_no_write", count, 5'd16);
    drain(17);
    check("drain_all_seen", 32'(exp_q.size()), 32'd0);
    check("drain_empty", rd_empty, 1'b1);
    check("drain_stays_frozen", state, 2'd3);
    check("rd_data_hold", rd_data, exp_entry(32'h4C));

    // 4. arm beats a simultaneous capture, then re-trigger
    arm = 1'b1;
    cap(32'h100, 1'b0);
    arm = 1'b0;
    check("arm_prio_state", state, 2'd1);
    check("arm_prio_count", count, 5'd0);
    cap(32'h104, 1'b1);
    check("rearm_cap_count", count, 5'd1);
    trig_pc = 32'h108;
    for (int i = 0; i < 5; i++) cap(32'h108 + 32'(i * 4), 1'b1);
    check("retrig_frozen", frozen, 1'b1);
    check("retrig_count", count, 5'd6);
    drain(6);
    check("retrig_drained", 32'(exp_q.size()), 32'd0);

    // 5. reset asynchronously in the middle of POST
    pulse_arm();
    trig_pc = 32'h200;
    cap(32'h1FC, 1'b0);
    cap(32'h200, 1'b0);
    cap(32'h204, 1'b0);
    cap(32'h208, 1'b0);
    check("midpost_state", state, 2'd2);
    check("midpost_count", count, 5'd4);
    reset = 1'b1;
    #1;
    check("async_reset_state", state, 2'd0);
    check("async_reset_count", count, 5'd0);
    check("async_reset_empty", rd_empty, 1'b1);
    step();
    reset = 1'b0;

`ifdef TRACE_CYCLE_EN
    // 6. stamps follow the free-running counter across its wrap
    pulse_arm();
    trig_pc = 32'h300;
    repeat (3) step();
    cap(32'h2F0, 1'b1);
    step();
    cap(32'h2F4, 1'b1);
    repeat (65536 - 4) step();
    cap(32'h2F8, 1'b1);
    cap(32'h300, 1'b1);
    for (int i = 1; i <= 4; i++) cap(32'h300 + 32'(i * 4), 1'b1);
    check("stamp_frozen", frozen, 1'b1);
    drain(8);
    check("stamp_drained", 32'(exp_q.size()), 32'd0);
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
